mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 24 ++
 rtl/mux_scan_ctrl_if.sv | 37 +++
 rtl/mux_scan_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the mux scan controller and its interface.
//   state_t  : controller FSM states (IDLE, SCAN, DONE)
//   DATA_W   : width of the scanned word / mux data bus
//   SEL_W    : width of the mux select
//   CNT_W    : width of the dwell counter
//   SEL_LAST : select value of the final mux input
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mux_scan_pkg

// File: rtl/mux_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_if
// Bundles the upstream word handshake, the downstream mux bus and the result
// handshake of the mux scan controller.
//   in_valid/in_ready/in_data       : word offered for scanning
//   mux_c/mux_s/mux_z               : data, select and output of the external 4:1 mux
//   out_valid/out_ready/out_data    : reassembled scan result
//   out_match                       : result equals the word that was scanned
//   busy                            : controller is not idle
// Modports: slave = controller side, master = environment side.
// -----------------------------------------------------------------------------
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] mux_c;
    logic [SEL_W-1:0]  mux_s;
    logic              mux_z;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_match;
    logic              busy;

    modport slave (
        input  in_valid, in_data, mux_z, out_ready,
        output in_ready, mux_c, mux_s, out_valid, out_data, out_match, busy
    );

    modport master (
        output in_valid, in_data, mux_z, out_ready,
        input  in_ready, mux_c, mux_s, out_valid, out_data, out_match, busy
    );

endinterface : mux_scan_ctrl_if

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Tests an external 4:1 mux by driving an accepted word onto its data bus and
// stepping the select through 0..3, holding each select value for DWELL
// cycles before sampling the mux output. The four samples are reassembled
// into a word (bit i = z with s=i) and presented with a match flag that says
// whether the mux reproduced the original word.
//
// Parameters:
//   DWELL : cycles each select value is held before z is sampled (1..15)
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_scan_ctrl_if.slave (word in, mux bus, result out, busy)
//
// Timing: accept edge -> 4*DWELL edges of scanning -> DONE, then out_valid
// rises on the following edge (4*DWELL+1 edges after accept) and is held
// until out_ready.
// -----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.slave  bus
);

    if (DWELL < 1 || DWELL > 15) begin : g_dwell_range
        $error("mux_scan_ctrl: DWELL=%0d is outside the legal range 1..15", DWELL);
    end

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t            state_q,     state_d;
    logic [DATA_W-1:0] mux_c_q,     mux_c_d;
    logic [SEL_W-1:0]  mux_s_q,     mux_s_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_match_q, out_match_d;

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        mux_c_d     = mux_c_q;
        mux_s_d     = mux_s_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_match_d = out_match_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mux_c_d  = bus.in_data;
                    mux_s_d  = '0;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = SCAN;
                end
            end

            SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    // Select has been stable for DWELL cycles: z is settled.
                    result_d[mux_s_q] = bus.mux_z;
                    cnt_d             = '0;
                    if (mux_s_q == SEL_LAST) begin
                        state_d = DONE;
                    end else begin
                        mux_s_d = mux_s_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                // First DONE cycle publishes the result; out_ready only counts
                // once out_valid is actually visible to the consumer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = result_q;
                    out_match_d = (result_q == mux_c_q);
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            mux_c_q     <= '0;
            mux_s_q     <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_match_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mux_c_q     <= mux_c_d;
            mux_s_q     <= mux_s_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_match_q <= out_match_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.mux_c     = mux_c_q;
    assign bus.mux_s     = mux_s_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_match = out_match_q;

endmodule : mux_scan_ctrl
